mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Single-port memory and MMIO arbiter between the CPU's instruction-fetch port and data (load/store) port. Grants at most one request per cycle onto the block-RAM word memory, or onto the UART-TX MMIO window when address bit `MMIO_BIT` is set. Returns read data one cycle after grant and flags out-of-range or misaligned accesses. Sits between the CPU core and `mem`/`simple_jtag_uart_tx` in `cpu_on_board`.

## Interface
- `MEM_WORDS`, 3000, memory depth in 32-bit words
- `MEM_AW`, 12, memory word-address width (≥ clog2(MEM_WORDS))
- `MMIO_BIT`, 31, address bit selecting the UART MMIO window
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits
- `clk` in 1, the only clock
- `reset` in 1, synchronous, active-high
- `if_req` in 1, fetch request; held with `if_addr` until `if_gnt`
- `if_addr` in 32, fetch byte address
- `if_gnt` out 1, one-cycle acceptance pulse
- `if_rvalid` out 1, fetch data valid
- `if_rdata` out 32, fetch data
- `d_req` in 1, data request; held with `d_we`/`d_addr`/`d_wdata` until `d_gnt`
- `d_we` in 1, 1 = store
- `d_addr` in 32, data byte address
- `d_wdata` in 32, store data
- `d_gnt` out 1, one-cycle acceptance pulse
- `d_rvalid` out 1, load data valid (loads only)
- `d_rdata` out 32, load data
- `bus_err` out 1, pulses with the grant of an erroneous access
- `mem_en` out 1, memory access this cycle
- `mem_we` out 1, memory write
- `mem_addr` out MEM_AW, word address = addr[MEM_AW+1:2]
- `mem_wdata` out 32, write data
- `mem_rdata` in 32, read data, valid one cycle after `mem_en && !mem_we`
- `uart_we` out 1, UART byte write strobe
- `uart_wdata` out 8, `d_wdata[7:0]`
- `uart_full` in 1, UART FIFO full

## Operation
- Classify each request combinationally:
  - MMIO: addr[MMIO_BIT]=1.
  - ERR: not MMIO and (addr[1:0]≠0 or addr[MMIO_BIT-1:2] ≥ MEM_WORDS).
  - MEM: otherwise.
- Fetch on MMIO is ERR.
- Data MMIO store is *blocked* while `uart_full`=1. It is not eligible, and fetch may be granted in its place; there is no head-of-line blocking.
- Arbitration among eligible requests:
  - Data wins, unless `starve_cnt == STARVE_MAX` and `if_req`=1, in which case fetch wins.
  - `starve_cnt` increments on each data grant while `if_req`=1 and fetch loses.
  - It clears on any fetch grant or whenever `if_req`=0, and saturates at STARVE_MAX.
- Grant actions, in the same cycle as `*_gnt`:
  - MEM: drive `mem_en`, plus `mem_we`/`mem_wdata` for stores.
  - MMIO store: `uart_we`=1.
  - MMIO load: no side effect.
  - ERR: `bus_err`=1, no memory or UART access.
- Response register records owner (IF/D) and source (MEM/MMIO/ERR) for granted reads. The next cycle it asserts the owner's `rvalid` with:
  - MEM: `mem_rdata`.
  - MMIO load: {31'b0, uart_full sampled at grant}.
  - ERR: 32'h0.
- Stores produce no `rvalid`.
- `if_rdata`/`d_rdata` are 0 when their `rvalid` is 0.

## Timing
- Request-to-grant is combinational: `gnt` can assert in the same cycle `req` rises.
- Read latency is exactly 1 cycle from grant to `rvalid`.
- Back-to-back grants every cycle are supported, including alternating owners. The response for grant N appears at cycle N+1 alongside grant N+1.
- Requester must hold `req` and its fields stable until `gnt`. Dropping `req` before `gnt` is legal and leaves no side effect.
- Requester must not change fields in the cycle `gnt` is high.
- `reset`=1 forces all outputs to 0 in that cycle's registered state:
  - clears the response register and `starve_cnt`;
  - an in-flight read's `rvalid` is suppressed;
  - combinational strobes (`gnt`, `mem_en`, `uart_we`, `bus_err`) are gated low while `reset`=1.
- `uart_full` rising in the same cycle as a pending MMIO store: no grant, no `uart_we`.

## Structure
- Package `cpu_bus_pkg`:
  - MMIO_BIT default.
  - `resp_src_t` enum {RESP_MEM, RESP_MMIO, RESP_ERR}.
  - `owner_t` enum {OWN_IF, OWN_D}.
  - Request classification function.
- One sub-module `starve_prio_arb`: two-input fixed-priority arbiter with the saturating starvation counter. Inputs are the eligible requests; outputs are one-hot grants.
- Top holds classification, response register, and output muxing.

## Test plan
- Reset mid-read:
  - Stimulus: grant a fetch of 0x0000_0010, assert `reset` the next cycle.
  - Required: no `if_rvalid`, all outputs 0, `starve_cnt`=0.
- Simultaneous requests:
  - Stimulus: `if_req`+`d_req` (load 0x40) every cycle for 6 cycles, memory word 16 = 0xDEADBEEF.
  - Required: data granted 4 times, fetch on the 5th, data on the 6th. `d_rvalid` carries 0xDEADBEEF one cycle after each data grant.
- MMIO store with backpressure:
  - Stimulus: store 0x8000_0000 data 0x41 with `uart_full`=1 for 3 cycles, `if_req` active.
  - Required: fetch granted in those cycles. After `uart_full` falls, `d_gnt`+`uart_we` pulse together with `uart_wdata`=0x41.
- Errors:
  - Stimulus: load 0x0000_2EE0 (word 3000), load 0x0000_0002, fetch 0x8000_0004.
  - Required: each gets `gnt`+`bus_err`, `mem_en`=0, `rvalid` next cycle with rdata 0.
- Store then load:
  - Stimulus: store 0x0000_0008 data 0x1234_5678, then load 0x0000_0008 back-to-back.
  - Required: `mem_we` on the first grant, `d_rvalid` with 0x1234_5678 after the second.
- MMIO status read:
  - Stimulus: load 0x8000_0000 with `uart_full`=1.
  - Required: `d_rdata`=0x0000_0001 one cycle later.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and request classification for the CPU memory/MMIO bus.
package cpu_bus_pkg;

  localparam int MMIO_BIT_DEF = 31;

  typedef enum logic [1:0] {RESP_MEM, RESP_MMIO, RESP_ERR} resp_src_t;
  typedef enum logic       {OWN_IF, OWN_D} owner_t;

  // Registered read response: who asked and where the data comes from.
  typedef struct packed {
    logic      vld;
    owner_t    owner;
    resp_src_t src;
    logic      status;
  } resp_t;

  // Word index is taken from every bit below the MMIO select, so addresses
  // that would alias into the memory's word-address range still flag ERR.
  function automatic resp_src_t classify(input logic [31:0] addr,
                                         input int          mmio_bit,
                                         input logic [31:0] mem_words);
    logic [31:0] word;
    word = (addr & ((32'h1 << mmio_bit) - 32'h1)) >> 2;
    if (((addr >> mmio_bit) & 32'h1) != 32'h0) return RESP_MMIO;
    if (addr[1:0] != 2'b00 || word >= mem_words) return RESP_ERR;
    return RESP_MEM;
  endfunction

endpackage

// File: rtl/starve_prio_arb.sv
// Two-input arbiter: data has priority until fetch has lost STARVE_MAX times in a row.
import cpu_bus_pkg::*;

module starve_prio_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_elig,
  input  logic d_elig,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          if_prio;

  assign if_prio = if_elig && (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_prio)      if_gnt = 1'b1;
      else if (d_elig)  d_gnt  = 1'b1;
      else if (if_elig) if_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !if_req || if_gnt)
      starve_cnt <= '0;
    else if (d_gnt && starve_cnt != CW'(STARVE_MAX))
      starve_cnt <= starve_cnt + CW'(1);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto block RAM and the UART-TX MMIO window, with 1-cycle read return.
import cpu_bus_pkg::*;

module mem_bus_arbiter #(
  parameter int MEM_WORDS  = 3000,
  parameter int MEM_AW     = 12,
  parameter int MMIO_BIT   = MMIO_BIT_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              bus_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              uart_we,
  output logic [7:0]        uart_wdata,
  input  logic              uart_full
);

  resp_src_t   if_cls, d_cls;
  logic        d_blocked, d_elig;
  resp_t       rsp;
  logic [31:0] rsp_data;

  // Fetch never touches MMIO; it is reported as an error instead.
  always_comb begin
    if_cls = classify(if_addr, MMIO_BIT, 32'(MEM_WORDS));
    if (if_cls == RESP_MMIO) if_cls = RESP_ERR;
    d_cls = classify(d_addr, MMIO_BIT, 32'(MEM_WORDS));
  end

  // A blocked UART store steps aside so fetch is not held behind it.
  assign d_blocked = (d_cls == RESP_MMIO) && d_we && uart_full;
  assign d_elig    = d_req && !d_blocked;

  starve_prio_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_elig (if_req),
    .d_elig  (d_elig),
    .if_gnt  (if_gnt),
    .d_gnt   (d_gnt)
  );

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    uart_we    = 1'b0;
    uart_wdata = '0;
    bus_err    = 1'b0;
    if (d_gnt) begin
      case (d_cls)
        RESP_MEM: begin
          mem_en   = 1'b1;
          mem_we   = d_we;
          mem_addr = d_addr[MEM_AW+1:2];
          if (d_we) mem_wdata = d_wdata;
        end
        RESP_MMIO: begin
          if (d_we) begin
            uart_we    = 1'b1;
            uart_wdata = d_wdata[7:0];
          end
        end
        default: bus_err = 1'b1;
      endcase
    end else if (if_gnt) begin
      if (if_cls == RESP_MEM) begin
        mem_en   = 1'b1;
        mem_addr = if_addr[MEM_AW+1:2];
      end else begin
        bus_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp <= '0;
    end else begin
      rsp.vld    <= if_gnt || (d_gnt && !d_we);
      rsp.owner  <= d_gnt ? OWN_D : OWN_IF;
      rsp.src    <= d_gnt ? d_cls : if_cls;
      rsp.status <= uart_full;
    end
  end

  always_comb begin
    case (rsp.src)
      RESP_MEM:  rsp_data = mem_rdata;
      RESP_MMIO: rsp_data = {31'b0, rsp.status};
      default:   rsp_data = '0;
    endcase
  end

  // Reset also masks a response already sitting in the register.
  assign if_rvalid = !reset && rsp.vld && (rsp.owner == OWN_IF);
  assign d_rvalid  = !reset && rsp.vld && (rsp.owner == OWN_D);
  assign if_rdata  = if_rvalid ? rsp_data : '0;
  assign d_rdata   = d_rvalid  ? rsp_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized run against a behavioural arbitration model.
module tb_mem_bus_arbiter;

  logic        clk, reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        bus_err, mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        uart_we, uart_full;
  logic [7:0]  uart_wdata;

  logic        preload, poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;
  logic [31:0] bmem [0:4095];

  int n_chk, n_fail;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .bus_err(bus_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .uart_we(uart_we), .uart_wdata(uart_wdata), .uart_full(uart_full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Block RAM stand-in driven by the DUT's memory port.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) bmem[i] <= init_val(i);
    end else if (poke_en) begin
      bmem[poke_addr] <= poke_data;
    end else if (mem_en && mem_we) begin
      bmem[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= bmem[mem_addr];
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; uart_full = 0;
  endtask

  task automatic do_reset();
    cyc(); idle(); reset = 1;
    cyc(); cyc(); reset = 0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] v);
    cyc(); idle(); poke_en = 1; poke_addr = a; poke_data = v;
    cyc(); poke_en = 0;
  endtask

  // Spec-level classification: 0 = memory, 1 = MMIO, 2 = error.
  function automatic int ref_cls(input logic [31:0] a, input bit fetch);
    if (a >= 32'h8000_0000) return fetch ? 2 : 1;
    if (a % 4 != 0) return 2;
    if (a / 4 >= 3000) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(9))
      0, 1, 2, 3, 4, 5: return 32'(4 * $urandom_range(7));
      6: return 32'(4 * 2999);
      7: return $urandom_range(1) ? 32'(4 * 3000) : 32'h0001_0000 + 32'(4 * $urandom_range(7));
      8: return 32'(4 * $urandom_range(7) + $urandom_range(3, 1));
      default: return 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
    endcase
  endfunction

  task automatic test_reset();
    idle(); reset = 1; preload = 1;
    cyc(); preload = 0; #1;
    n_chk++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, bus_err, mem_en, mem_we,
         mem_addr, mem_wdata, uart_we, uart_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_idle: outputs not all zero (if_gnt=%b d_gnt=%b mem_en=%b)", if_gnt, d_gnt, mem_en);
    end
    reset = 0;
    poke(12'd4, 32'hCAFE_F00D);
    // fetch granted, then reset in the response cycle
    cyc(); if_req = 1; if_addr = 32'h10; #1;
    n_chk++;
    if ({if_gnt, mem_en, mem_addr} !== {1'b1, 1'b1, 12'd4}) begin
      n_fail++; $display("FAIL reset_fetch_gnt: got gnt=%b en=%b addr=%h want 1 1 004", if_gnt, mem_en, mem_addr);
    end
    cyc(); if_req = 0; reset = 1; #1;
    n_chk++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, bus_err, mem_en, mem_we,
         mem_addr, mem_wdata, uart_we, uart_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mid_read: if_rvalid=%b if_rdata=%h want 0", if_rvalid, if_rdata);
    end
    cyc(); reset = 0; #1;
    n_chk++;
    if (if_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_after_release: if_rvalid=%b want 0", if_rvalid);
    end
    // build up starvation, then reset while a data read is in flight and fetch still waits
    for (int i = 0; i < 3; i++) begin
      cyc(); if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h40; #1;
    end
    cyc(); reset = 1; #1;
    n_chk++;
    if ({if_gnt, d_gnt, d_rvalid, d_rdata, mem_en} !== '0) begin
      n_fail++; $display("FAIL reset_strobes_gated: gnt=%b%b d_rvalid=%b mem_en=%b want 0", if_gnt, d_gnt, d_rvalid, mem_en);
    end
    cyc(); reset = 0; idle(); #1;
    n_chk++;
    if (dut.u_arb.starve_cnt !== 0) begin
      n_fail++; $display("FAIL reset_starve_cnt: got %0d want 0", dut.u_arb.starve_cnt);
    end
  endtask

  task automatic test_simultaneous();
    logic ed, edv;
    do_reset();
    poke(12'd16, 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++) begin
      cyc(); if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h40; #1;
      ed  = (i != 4);
      edv = (i >= 1 && i <= 4);
      n_chk++;
      if ({if_gnt, d_gnt} !== {!ed, ed}) begin
        n_fail++; $display("FAIL simul_gnt[%0d]: if_gnt=%b d_gnt=%b want %b %b", i, if_gnt, d_gnt, !ed, ed);
      end
      n_chk++;
      if ({d_rvalid, d_rdata} !== {edv, edv ? 32'hDEAD_BEEF : 32'h0}) begin
        n_fail++; $display("FAIL simul_rdata[%0d]: rvalid=%b data=%h want %b", i, d_rvalid, d_rdata, edv);
      end
    end
    cyc(); idle(); #1;
    n_chk++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL simul_last_rdata: rvalid=%b data=%h want 1 deadbeef", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_mmio_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(); if_req = 1; if_addr = 32'h20;
      d_req = 1; d_we = 1; d_addr = 32'h8000_0000; d_wdata = 32'h41; uart_full = 1; #1;
      n_chk++;
      if ({if_gnt, d_gnt, uart_we} !== 3'b100) begin
        n_fail++; $display("FAIL uart_full_block[%0d]: if_gnt=%b d_gnt=%b uart_we=%b want 1 0 0", i, if_gnt, d_gnt, uart_we);
      end
    end
    cyc(); uart_full = 0; if_req = 0; #1;
    n_chk++;
    if ({d_gnt, uart_we, uart_wdata, mem_en} !== {1'b1, 1'b1, 8'h41, 1'b0}) begin
      n_fail++; $display("FAIL uart_store: d_gnt=%b uart_we=%b wdata=%h mem_en=%b want 1 1 41 0", d_gnt, uart_we, uart_wdata, mem_en);
    end
    cyc(); idle(); #1;
    n_chk++;
    if ({d_rvalid, if_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL uart_store_no_rvalid: d_rvalid=%b if_rvalid=%b want 0 0", d_rvalid, if_rvalid);
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [3] = '{32'h0000_2EE0, 32'h0000_0002, 32'h8000_0004};
    bit          isf[3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(); idle();
      if (isf[i]) begin if_req = 1; if_addr = ea[i]; end
      else begin d_req = 1; d_we = 0; d_addr = ea[i]; end
      #1;
      n_chk++;
      if ({if_gnt, d_gnt, bus_err, mem_en} !== {isf[i], !isf[i], 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL err_gnt[%h]: gnt=%b%b bus_err=%b mem_en=%b", ea[i], if_gnt, d_gnt, bus_err, mem_en);
      end
      cyc(); idle(); #1;
      n_chk++;
      if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== {isf[i], !isf[i], 64'h0}) begin
        n_fail++; $display("FAIL err_resp[%h]: rvalid=%b%b rdata=%h/%h want zero data", ea[i], if_rvalid, d_rvalid, if_rdata, d_rdata);
      end
    end
  endtask

  task automatic test_store_load();
    do_reset();
    cyc(); d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'h1234_5678; #1;
    n_chk++;
    if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 12'd2, 32'h1234_5678}) begin
      n_fail++; $display("FAIL store: gnt=%b en=%b we=%b addr=%h wdata=%h", d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    cyc(); d_we = 0; #1;
    n_chk++;
    if ({d_gnt, mem_en, mem_we, d_rvalid} !== 4'b1100) begin
      n_fail++; $display("FAIL load_gnt: gnt=%b en=%b we=%b rvalid=%b want 1 1 0 0", d_gnt, mem_en, mem_we, d_rvalid);
    end
    cyc(); idle(); #1;
    n_chk++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'h1234_5678}) begin
      n_fail++; $display("FAIL load_back: rvalid=%b data=%h want 1 12345678", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_mmio_status();
    do_reset();
    for (int f = 1; f >= 0; f--) begin
      cyc(); d_req = 1; d_we = 0; d_addr = 32'h8000_0000; uart_full = f[0]; #1;
      n_chk++;
      if ({d_gnt, mem_en, uart_we, bus_err} !== 4'b1000) begin
        n_fail++; $display("FAIL mmio_rd_gnt[%0d]: gnt=%b en=%b uart_we=%b err=%b", f, d_gnt, mem_en, uart_we, bus_err);
      end
      cyc(); idle(); uart_full = !f[0]; #1;
      n_chk++;
      if ({d_rvalid, d_rdata} !== {1'b1, 31'b0, f[0]}) begin
        n_fail++; $display("FAIL mmio_status[%0d]: rvalid=%b data=%h want %0d", f, d_rvalid, d_rdata, f);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rmem [0:2999];
    int          starve, ic, dc;
    logic        g_if, g_d, d_el, e_if, e_d, e_en, e_we, e_uart, e_err;
    logic        ep_if_v, ep_d_v;
    logic [31:0] ep_if_d, ep_d_d, wa;
    cyc(); idle(); reset = 1; preload = 1;
    cyc(); preload = 0; cyc(); reset = 0;
    for (int i = 0; i < 3000; i++) rmem[i] = init_val(i);
    starve = 0; g_if = 0; g_d = 0; ep_if_v = 0; ep_d_v = 0; ep_if_d = 0; ep_d_d = 0;
    for (int c = 0; c < 800; c++) begin
      cyc();
      if (g_if) if_req = 0;
      if (g_d)  d_req = 0;
      if (!if_req && $urandom_range(2) != 0) begin if_req = 1; if_addr = pick_addr(); end
      if (!d_req && $urandom_range(1) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(1)); d_addr = pick_addr(); d_wdata = $urandom;
      end
      uart_full = ($urandom_range(3) == 0);
      #1;
      ic   = ref_cls(if_addr, 1);
      dc   = ref_cls(d_addr, 0);
      d_el = d_req && !(dc == 1 && d_we && uart_full);
      e_if = if_req && (starve == 4 || !d_el);
      e_d  = d_el && !e_if;
      e_en   = (e_if && ic == 0) || (e_d && dc == 0);
      e_we   = e_d && dc == 0 && d_we;
      e_uart = e_d && dc == 1 && d_we;
      e_err  = (e_if && ic == 2) || (e_d && dc == 2);
      n_chk++;
      if ({if_gnt, d_gnt, mem_en, mem_we, uart_we, bus_err, if_rvalid, d_rvalid} !==
          {e_if, e_d, e_en, e_we, e_uart, e_err, ep_if_v, ep_d_v}) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: got gnt=%b%b en=%b we=%b uw=%b err=%b rv=%b%b want %b%b %b %b %b %b %b%b",
                 c, if_gnt, d_gnt, mem_en, mem_we, uart_we, bus_err, if_rvalid, d_rvalid,
                 e_if, e_d, e_en, e_we, e_uart, e_err, ep_if_v, ep_d_v);
      end
      n_chk++;
      if ({if_rdata, d_rdata} !== {ep_if_v ? ep_if_d : 32'h0, ep_d_v ? ep_d_d : 32'h0}) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h/%h", c, if_rdata, d_rdata, ep_if_d, ep_d_d);
      end
      if (e_en) begin
        wa = e_d ? d_addr / 4 : if_addr / 4;
        n_chk++;
        if (mem_addr !== wa[11:0] || (e_we && mem_wdata !== d_wdata)) begin
          n_fail++; $display("FAIL rand_mem[%0d]: addr=%h wdata=%h want %h %h", c, mem_addr, mem_wdata, wa[11:0], d_wdata);
        end
      end
      if (e_uart) begin
        n_chk++;
        if (uart_wdata !== d_wdata[7:0]) begin
          n_fail++; $display("FAIL rand_uart[%0d]: got %h want %h", c, uart_wdata, d_wdata[7:0]);
        end
      end
      ep_if_v = e_if;
      ep_if_d = (ic == 0) ? rmem[if_addr / 4] : 32'h0;
      ep_d_v  = e_d && !d_we;
      ep_d_d  = (dc == 0) ? rmem[d_addr / 4] : (dc == 1) ? {31'b0, uart_full} : 32'h0;
      if (e_we) rmem[d_addr / 4] = d_wdata;
      if (!if_req || e_if) starve = 0;
      else if (e_d && starve < 4) starve++;
      g_if = e_if; g_d = e_d;
    end
    cyc(); idle();
  endtask

  initial begin
    clk = 0; reset = 1; preload = 0; poke_en = 0; poke_addr = 0; poke_data = 0;
    n_chk = 0; n_fail = 0;
    idle();
    test_reset();
    test_simultaneous();
    test_mmio_backpressure();
    test_errors();
    test_store_load();
    test_mmio_status();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
